// File: rtl/tftlcd_pkg.sv
// Shared constants for the TFT-LCD frame-shadow stage: register bank geometry
// and Vsync polarity, plus the idle-level helper used for synchronizer reset values.
package tftlcd_pkg;
    localparam int NUM_REGS = 7;
    localparam int REG_W    = 32;
    localparam bit VSYNC_ACTIVE_LOW = 1'b1;

    // Idle level of an active-low signal is 1, of an active-high signal 0.
    function automatic logic inactive_level(input bit active_low);
        return active_low;
    endfunction

    localparam logic VSYNC_INACTIVE = inactive_level(VSYNC_ACTIVE_LOW);
endpackage

// File: rtl/tftlcd_sync_edge.sv
// Synchronizes an asynchronous level and emits a one-cycle pulse when it becomes active.
// Latency: 3 clocks from the input transition to the pulse; no backpressure.
module tftlcd_sync_edge
    import tftlcd_pkg::*;
#(
    parameter bit ACTIVE_LOW = VSYNC_ACTIVE_LOW
) (
    input  logic TFTLCD_CLK,
    input  logic TFTLCD_nRESET,
    input  logic async_level,
    output logic assert_pulse
);
    localparam logic INACTIVE = inactive_level(ACTIVE_LOW);

    logic sync_meta;
    logic sync_lvl;
    logic sync_prev;

    // Flops idle at the inactive level so reset release never looks like a sync start.
    always_ff @(posedge TFTLCD_CLK or negedge TFTLCD_nRESET) begin
        if (!TFTLCD_nRESET) begin
            sync_meta    <= INACTIVE;
            sync_lvl     <= INACTIVE;
            sync_prev    <= INACTIVE;
            assert_pulse <= 1'b0;
        end else begin
            sync_meta    <= async_level;
            sync_lvl     <= sync_meta;
            sync_prev    <= sync_lvl;
            assert_pulse <= (sync_lvl != INACTIVE) && (sync_prev == INACTIVE);
        end
    end
endmodule

// File: rtl/tftlcd_frame_shadow.sv
// Frame-synchronous shadow of the live display registers, plus frame counter and blink phase.
// Shadow loads one clock after frame_tick (4 clocks after the vsync_in edge); no backpressure.
module tftlcd_frame_shadow
    import tftlcd_pkg::*;
#(
    parameter int NUM_REGS         = tftlcd_pkg::NUM_REGS,
    parameter bit VSYNC_ACTIVE_LOW = tftlcd_pkg::VSYNC_ACTIVE_LOW,
    parameter int FRAME_CNT_W      = 16,
    parameter int BLINK_FRAMES     = 30
) (
    input  logic                      TFTLCD_CLK,
    input  logic                      TFTLCD_nRESET,
    input  logic                      vsync_in,
    input  logic [REG_W*NUM_REGS-1:0] live_regs,
    input  logic                      commit_req,
    input  logic                      auto_update,
    output logic [REG_W*NUM_REGS-1:0] shadow_regs,
    output logic                      commit_pending,
    output logic                      commit_done,
    output logic [FRAME_CNT_W-1:0]    frame_count,
    output logic                      blink
);
    localparam int             BLINK_W    = $clog2(BLINK_FRAMES) + 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

    logic               frame_tick;
    logic               commit_req_q;
    logic               req_edge;
    logic               do_copy;
    logic [BLINK_W-1:0] blink_cnt;

    tftlcd_sync_edge #(
        .ACTIVE_LOW (VSYNC_ACTIVE_LOW)
    ) u_vsync_edge (
        .TFTLCD_CLK    (TFTLCD_CLK),
        .TFTLCD_nRESET (TFTLCD_nRESET),
        .async_level   (vsync_in),
        .assert_pulse  (frame_tick)
    );

    // A request arriving on the tick itself is not eligible for that frame.
    assign req_edge = commit_req & ~commit_req_q;
    assign do_copy  = frame_tick & (commit_pending | auto_update);

    always_ff @(posedge TFTLCD_CLK or negedge TFTLCD_nRESET) begin
        if (!TFTLCD_nRESET) begin
            shadow_regs    <= '0;
            commit_pending <= 1'b0;
            commit_done    <= 1'b0;
            commit_req_q   <= 1'b0;
        end else begin
            commit_req_q <= commit_req;
            commit_done  <= do_copy;
            if (do_copy) begin
                shadow_regs    <= live_regs;
                commit_pending <= req_edge;
            end else if (req_edge) begin
                commit_pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge TFTLCD_CLK or negedge TFTLCD_nRESET) begin
        if (!TFTLCD_nRESET) begin
            frame_count <= '0;
            blink_cnt   <= '0;
            blink       <= 1'b0;
        end else if (frame_tick) begin
            frame_count <= frame_count + 1'b1;
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= '0;
                blink     <= ~blink;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_tftlcd_frame_shadow.sv
// Scoreboard bench for tftlcd_frame_shadow: expected shadow snapshots are queued at the
// vsync edge and popped on commit_done; per-frame latency, counter and blink checks inline.
module tb_tftlcd_frame_shadow;
    import tftlcd_pkg::*;

    localparam int FCW = 4;
    localparam int BF  = 2;
    localparam int W   = REG_W * NUM_REGS;

    logic           clk         = 1'b0;
    logic           rst_n       = 1'b0;
    logic           vsync_in    = 1'b1;
    logic           commit_req  = 1'b0;
    logic           auto_update = 1'b0;
    logic [W-1:0]   live_regs   = '0;
    logic [W-1:0]   shadow_regs;
    logic           commit_pending;
    logic           commit_done;
    logic [FCW-1:0] frame_count;
    logic           blink;

    int n_vec = 0;
    int n_err = 0;

    logic [W-1:0] sb[$];
    logic [W-1:0] exp_shadow  = '0;
    bit           exp_pending = 1'b0;
    int           ticks       = 0;

    tftlcd_frame_shadow #(
        .NUM_REGS         (NUM_REGS),
        .VSYNC_ACTIVE_LOW (1'b1),
        .FRAME_CNT_W      (FCW),
        .BLINK_FRAMES     (BF)
    ) dut (
        .TFTLCD_CLK     (clk),
        .TFTLCD_nRESET  (rst_n),
        .vsync_in       (vsync_in),
        .live_regs      (live_regs),
        .commit_req     (commit_req),
        .auto_update    (auto_update),
        .shadow_regs    (shadow_regs),
        .commit_pending (commit_pending),
        .commit_done    (commit_done),
        .frame_count    (frame_count),
        .blink          (blink)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_reg(input int k, input logic [31:0] v);
        live_regs[k*REG_W +: REG_W] = v;
    endtask

    task automatic commit_pulse();
        @(negedge clk);
        commit_req = 1'b1;
        @(negedge clk);
        commit_req  = 1'b0;
        exp_pending = 1'b1;
        chk("pending_arm", commit_pending, 1);
    endtask

    // One vsync assertion; req_at_tick raises commit_req in the frame_tick cycle.
    task automatic vsync_pulse(input bit req_at_tick);
        logic [W-1:0] snap;
        bit           copy;
        @(negedge clk);
        vsync_in = 1'b0;
        copy = exp_pending | auto_update;
        snap = live_regs;
        if (copy) sb.push_back(snap);
        repeat (3) @(negedge clk);
        chk("pre_tick_shadow", shadow_regs, exp_shadow);
        chk("pre_tick_pending", commit_pending, exp_pending);
        chk("pre_tick_done", commit_done, 0);
        if (req_at_tick) commit_req = 1'b1;
        @(negedge clk);
        ticks++;
        if (copy) exp_shadow = snap;
        exp_pending = req_at_tick ? 1'b1 : (copy ? 1'b0 : exp_pending);
        chk("tick_shadow", shadow_regs, exp_shadow);
        chk("tick_done", commit_done, copy);
        chk("tick_pending", commit_pending, exp_pending);
        chk("frame_count", frame_count, ticks % (1 << FCW));
        chk("blink", blink, (ticks / BF) % 2);
        @(negedge clk);
        chk("done_width", commit_done, 0);
        commit_req = 1'b0;
        repeat (2) @(negedge clk);
        vsync_in = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst_n && commit_done) begin
            if (sb.size() == 0) chk("unexp_done", commit_done, 0);
            else                chk("sb_shadow", shadow_regs, sb.pop_front());
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] old6;
        repeat (2) @(negedge clk);
        chk("rst_shadow", shadow_regs, 0);
        chk("rst_pending", commit_pending, 0);
        chk("rst_done", commit_done, 0);
        chk("rst_frame", frame_count, 0);
        chk("rst_blink", blink, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // No commit: shadow stays zero for three frames.
        for (int k = 0; k < NUM_REGS; k++) set_reg(k, 32'hA5A5A5A5);
        for (int i = 0; i < 3; i++) vsync_pulse(1'b0);

        // Software commit.
        set_reg(0, 32'h12345678);
        commit_pulse();
        repeat (4) @(negedge clk);
        chk("pending_hold", commit_pending, 1);
        vsync_pulse(1'b0);

        // Auto update every frame; mid-frame change must not leak through.
        auto_update = 1'b1;
        vsync_pulse(1'b0);
        old6 = exp_shadow[6*REG_W +: REG_W];
        set_reg(6, 32'hDEADBEEF);
        repeat (3) @(negedge clk);
        chk("reg6_hold", shadow_regs[6*REG_W +: REG_W], old6);
        vsync_pulse(1'b0);
        chk("reg6_new", shadow_regs[6*REG_W +: REG_W], 32'hDEADBEEF);
        set_reg(6, 32'h0BADF00D);
        vsync_pulse(1'b0);
        auto_update = 1'b0;

        // Request edge coincident with tick while idle: deferred one frame.
        set_reg(1, 32'h11112222);
        vsync_pulse(1'b1);
        set_reg(2, 32'h33334444);
        vsync_pulse(1'b0);

        // Request edge coincident with a copying tick: stays armed for another copy.
        commit_pulse();
        set_reg(3, 32'h55556666);
        vsync_pulse(1'b1);
        set_reg(4, 32'h77778888);
        vsync_pulse(1'b0);

        // Run past the 4-bit frame counter wrap.
        while (ticks < 18) begin
            set_reg(5, 32'(ticks));
            vsync_pulse(1'b0);
        end

        // Asynchronous reset while a request is armed.
        commit_pulse();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_shadow", shadow_regs, 0);
        chk("mid_rst_pending", commit_pending, 0);
        chk("mid_rst_frame", frame_count, 0);
        chk("mid_rst_blink", blink, 0);
        chk("mid_rst_done", commit_done, 0);
        sb.delete();
        exp_shadow  = '0;
        exp_pending = 1'b0;
        ticks       = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        vsync_pulse(1'b0);

        chk("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/tftlcd_frame_shadow.md
Name: tftlcd_frame_shadow

Overview:
- Upstream stage of the TFT-LCD controller, in the TFTLCD_CLK domain.
- Takes the seven live 32-bit display registers written by the bus, plus the controller's Vsync output.
- Presents a shadow copy to the controller's register inputs. The shadow only updates at the start of vertical sync, so tearing mid-frame cannot occur.
- Also provides a frame counter and a frame-based blink phase for animated grid content.

Parameters:
- NUM_REGS, 7, number of 32-bit display registers shadowed.
- VSYNC_ACTIVE_LOW, 1, polarity of vsync_in (1 = sync asserted when low).
- FRAME_CNT_W, 16, width of frame_count.
- BLINK_FRAMES, 30, frames per blink half-period; must be >= 1.

Ports:
- TFTLCD_CLK  in  1  block clock; all logic is on its rising edge.
- TFTLCD_nRESET  in  1  asynchronous active-low reset.
- vsync_in  in  1  controller Vsync; produced on the divided pixel clock, treated as asynchronous.
- live_regs  in  32*NUM_REGS  bus-written registers; reg k occupies bits [32k+31:32k].
- commit_req  in  1  software commit strobe; rising edge requests an update.
- auto_update  in  1  level; when 1, the shadow copies live_regs every frame.
- shadow_regs  out  32*NUM_REGS  frame-stable copy, wired to the controller's reg_0..reg_6.
- commit_pending  out  1  a request is armed and waiting for the next frame boundary.
- commit_done  out  1  one-cycle pulse marking the cycle shadow_regs took new values.
- frame_count  out  FRAME_CNT_W  number of frame boundaries since reset; wraps.
- blink  out  1  toggles every BLINK_FRAMES frame boundaries.

Behaviour:
- Reset (asynchronous, TFTLCD_nRESET=0):
  - shadow_regs=0, commit_pending=0, commit_done=0, frame_count=0, blink=0.
  - Blink counter=0; commit_req edge register=0.
  - Vsync synchronizer flops load the inactive level (1 if VSYNC_ACTIVE_LOW, else 0).
- Reset mid-operation: any armed request is discarded. No partial shadow update is possible, because the copy is a single-cycle register load.
- Vsync path:
  - Two-flop synchronizer, then a registered previous value.
  - frame_tick = 1 for exactly one cycle when the synchronized vsync goes inactive->active.
  - Latency is 3 TFTLCD_CLK cycles from the vsync_in transition to frame_tick.
- Commit edge: req_edge = commit_req & ~commit_req_q, where commit_req_q is a registered copy. Holding commit_req high gives a single edge.
- Arming rule: commit_pending sets on req_edge and clears on a frame_tick that performs a copy.
- Update rule: on a cycle with frame_tick & (commit_pending | auto_update):
  - shadow_regs <= live_regs as sampled in that cycle.
  - commit_done = 1 the following cycle, aligned with the new shadow value.
  - commit_pending <= 0, unless req_edge occurs in the same cycle, in which case it stays 1 and another copy happens at the next frame_tick.
- Simultaneous edge and tick: req_edge with frame_tick while commit_pending=0 and auto_update=0 → no copy this frame; the request is armed for the next frame.
- No tick: live_regs changes never affect shadow_regs outside the update cycle.
- Frame counter: frame_count increments by 1 on every frame_tick, whether or not a copy happens. It wraps from 2^FRAME_CNT_W-1 to 0.
- Blink:
  - A blink counter of width clog2(BLINK_FRAMES)+1 increments on frame_tick.
  - At BLINK_FRAMES-1 the counter returns to 0 and blink toggles.
  - BLINK_FRAMES=1 toggles blink every frame.
- Registered outputs: all outputs come directly from flops; there is no combinational path from inputs to outputs.

Decomposition:
- Shared package tftlcd_pkg: NUM_REGS=7, REG_W=32, VSYNC_ACTIVE_LOW, and the inactive-level constant used by the reset value.
- One sub-module, tftlcd_sync_edge: 2-flop synchronizer, edge detector and polarity handling. Inputs: clock, reset, async level, polarity parameter. Output: one-cycle assert pulse.
- Shadow bank, pending flag and counters stay in the top.

Test Plan:
- Reset release, then live_regs=all 0xA5A5A5A5 with no commit and three vsync pulses → shadow_regs stays 0; frame_count=3; commit_done never asserts.
- commit_req pulse with live reg0=0x12345678, then vsync falls → commit_pending=1 until the tick. shadow reg0=0x12345678 on the 4th TFTLCD_CLK after the vsync_in fall; commit_done high for exactly 1 cycle; commit_pending=0.
- auto_update=1, live reg6 changed to 0xDEADBEEF mid-frame → shadow reg6 unchanged until the next tick, then 0xDEADBEEF. Repeats every frame.
- commit_req edge in the same cycle as frame_tick with pending=0 → no copy at that tick. Copy occurs at the following tick.
- BLINK_FRAMES=2, six vsync pulses → blink sequence 0,0,1,1,0,0,1 at ticks 0..6. frame_count forced near 0xFFFF wraps to 0.
- Assert TFTLCD_nRESET=0 while commit_pending=1 → all outputs return to reset values asynchronously. After release, a vsync produces no copy.
